// File: rtl/ct_mat_cmplt_arb_if.sv
// Completion bundle between matrix execution units, the completion arbiter and the RTU.
// The slave side is the arbiter.
interface ct_mat_cmplt_arb_if #(
  parameter int NUM_CH = 3,
  parameter int IID_W  = 7
);
  logic                    rtu_yy_xx_flush;
  logic [NUM_CH-1:0]       ch_cmplt_vld;
  logic [NUM_CH*IID_W-1:0] ch_cmplt_iid;
  logic [NUM_CH-1:0]       ch_cmplt_rdy;
  logic                    mat_rtu_pipe8_cmplt;
  logic [IID_W-1:0]        mat_rtu_pipe8_iid;
  logic                    mat_cmplt_pend;
  logic                    mat_cmplt_ovf_err;

  modport master (
    output rtu_yy_xx_flush, ch_cmplt_vld, ch_cmplt_iid,
    input  ch_cmplt_rdy, mat_rtu_pipe8_cmplt, mat_rtu_pipe8_iid, mat_cmplt_pend,
           mat_cmplt_ovf_err
  );

  modport slave (
    input  rtu_yy_xx_flush, ch_cmplt_vld, ch_cmplt_iid,
    output ch_cmplt_rdy, mat_rtu_pipe8_cmplt, mat_rtu_pipe8_iid, mat_cmplt_pend,
           mat_cmplt_ovf_err
  );
endinterface

// File: rtl/ct_mat_cmplt_arb.sv
// Matrix completion arbiter: per-channel completion FIFOs drained round-robin onto the single
// pipe8 RTU completion port, one IID per cycle, with flush and a sticky overflow error.
module ct_mat_cmplt_arb #(
  parameter int NUM_CH = 3,
  parameter int DEPTH  = 2,
  parameter int IID_W  = 7
) (
  input logic              forever_cpuclk,
  input logic              cpurst,
  ct_mat_cmplt_arb_if.slave io_bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int RR_W  = $clog2(NUM_CH);

  logic [IID_W-1:0] r_mem    [NUM_CH][DEPTH];
  logic [PTR_W-1:0] r_rd_ptr [NUM_CH];
  logic [PTR_W-1:0] r_wr_ptr [NUM_CH];
  logic [CNT_W-1:0] r_cnt    [NUM_CH];
  logic [RR_W-1:0]  r_rr_ptr;
  logic             r_cmplt;
  logic [IID_W-1:0] r_iid;
  logic             r_ovf;

  logic [NUM_CH-1:0] w_rdy;
  logic [NUM_CH-1:0] w_nonempty;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic              w_drop;
  logic              w_flush;
  logic              w_gnt_vld;
  logic [RR_W-1:0]   w_gnt;
  logic [RR_W-1:0]   w_rr_nxt;
  logic [IID_W-1:0]  w_head;
  int                w_idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_flush = io_bus.rtu_yy_xx_flush;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      w_rdy[k]      = (r_cnt[k] != CNT_W'(DEPTH));
      w_nonempty[k] = (r_cnt[k] != '0);
    end
    w_push = io_bus.ch_cmplt_vld & w_rdy & {NUM_CH{~w_flush}};
    w_drop = |(io_bus.ch_cmplt_vld & ~w_rdy) & ~w_flush;
  end

  // Only entries registered at the start of the cycle compete; no push-to-grant bypass.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_idx     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = (int'(r_rr_ptr) + i) % NUM_CH;
      if (!w_gnt_vld && w_nonempty[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = RR_W'(w_idx);
      end
    end
  end

  always_comb begin
    w_pop  = '0;
    w_head = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_gnt_vld && (w_gnt == RR_W'(k))) begin
        w_pop[k] = 1'b1;
        w_head   = r_mem[k][r_rd_ptr[k]];
      end
    end
    w_rr_nxt = (w_gnt == RR_W'(NUM_CH - 1)) ? '0 : w_gnt + RR_W'(1);
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_rd_ptr[k] <= '0;
        r_wr_ptr[k] <= '0;
        r_cnt[k]    <= '0;
      end
      r_rr_ptr <= '0;
      r_cmplt  <= 1'b0;
      r_iid    <= '0;
      r_ovf    <= 1'b0;
    end else if (w_flush) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_rd_ptr[k] <= '0;
        r_wr_ptr[k] <= '0;
        r_cnt[k]    <= '0;
      end
      r_rr_ptr <= '0;
      r_cmplt  <= 1'b0;
      r_iid    <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_push[k]) r_wr_ptr[k] <= ptr_inc(r_wr_ptr[k]);
        if (w_pop[k])  r_rd_ptr[k] <= ptr_inc(r_rd_ptr[k]);
        if (w_push[k] && !w_pop[k]) begin
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
        end else if (!w_push[k] && w_pop[k]) begin
          r_cnt[k] <= r_cnt[k] - CNT_W'(1);
        end
      end
      if (w_gnt_vld) r_rr_ptr <= w_rr_nxt;
      r_cmplt <= w_gnt_vld;
      r_iid   <= w_gnt_vld ? w_head : '0;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Storage needs no reset: occupancy is tracked by the counts alone.
  always_ff @(posedge forever_cpuclk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_push[k]) r_mem[k][r_wr_ptr[k]] <= io_bus.ch_cmplt_iid[k*IID_W +: IID_W];
    end
  end

  assign io_bus.ch_cmplt_rdy        = w_rdy;
  assign io_bus.mat_cmplt_pend      = |w_nonempty;
  assign io_bus.mat_rtu_pipe8_cmplt = r_cmplt;
  assign io_bus.mat_rtu_pipe8_iid   = r_iid;
  assign io_bus.mat_cmplt_ovf_err   = r_ovf;
endmodule

// File: tb/tb_ct_mat_cmplt_arb.sv
// Bench for ct_mat_cmplt_arb: directed scenarios then randomized traffic, all checked each
// cycle against a queue-based reference model of the completion arbiter.
module tb_ct_mat_cmplt_arb;
  localparam int NUM_CH = 3;
  localparam int DEPTH  = 2;
  localparam int IID_W  = 7;

  logic clk;
  logic rst;

  ct_mat_cmplt_arb_if #(.NUM_CH(NUM_CH), .IID_W(IID_W)) bus ();

  ct_mat_cmplt_arb #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .IID_W(IID_W)) dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .io_bus         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  int unsigned q [NUM_CH][$];
  int          rr;
  bit          m_ovf;
  bit          m_cmplt;
  int unsigned m_iid;

  int n_tests = 0;
  int n_fail  = 0;
  int next_id = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string pfx);
    logic [NUM_CH-1:0] e_rdy;
    bit                e_pend;
    e_pend = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      e_rdy[k] = (q[k].size() != DEPTH);
      if (q[k].size() != 0) e_pend = 1;
    end
    check({pfx, ".cmplt"}, 32'(bus.mat_rtu_pipe8_cmplt), 32'(m_cmplt));
    check({pfx, ".iid"},   32'(bus.mat_rtu_pipe8_iid),   m_iid);
    check({pfx, ".pend"},  32'(bus.mat_cmplt_pend),      32'(e_pend));
    check({pfx, ".rdy"},   32'(bus.ch_cmplt_rdy),        32'(e_rdy));
    check({pfx, ".ovf"},   32'(bus.mat_cmplt_ovf_err),   32'(m_ovf));
  endtask

  task automatic model_clear();
    for (int k = 0; k < NUM_CH; k++) q[k].delete();
    rr      = 0;
    m_cmplt = 0;
    m_iid   = 0;
  endtask

  task automatic set_ch(input int k, input int unsigned id);
    bus.ch_cmplt_vld[k]                  = 1'b1;
    bus.ch_cmplt_iid[k*IID_W +: IID_W]   = IID_W'(id);
  endtask

  // One clock: advance model with the currently driven inputs, clock DUT, compare, clear inputs.
  task automatic step(input string pfx);
    int pre_sz [NUM_CH];
    int g;
    bit gv;
    int idx;
    for (int k = 0; k < NUM_CH; k++) pre_sz[k] = q[k].size();
    gv = 0;
    g  = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (rr + i) % NUM_CH;
      if (!gv && pre_sz[idx] != 0) begin
        gv = 1;
        g  = idx;
      end
    end
    if (bus.rtu_yy_xx_flush) begin
      model_clear();
    end else begin
      if (gv) begin
        m_cmplt = 1;
        m_iid   = q[g].pop_front();
        rr      = (g + 1) % NUM_CH;
      end else begin
        m_cmplt = 0;
        m_iid   = 0;
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (bus.ch_cmplt_vld[k]) begin
          if (pre_sz[k] < DEPTH) q[k].push_back(int'(bus.ch_cmplt_iid[k*IID_W +: IID_W]));
          else m_ovf = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    check_all(pfx);
    bus.ch_cmplt_vld    = '0;
    bus.rtu_yy_xx_flush = 1'b0;
  endtask

  task automatic do_reset(input string pfx);
    rst = 1'b1;
    #1;
    model_clear();
    m_ovf = 0;
    check_all(pfx);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                 = 1'b0;
    bus.ch_cmplt_vld    = '0;
    bus.ch_cmplt_iid    = '0;
    bus.rtu_yy_xx_flush = 1'b0;
    model_clear();
    m_ovf = 0;
    #2;
    do_reset("reset");

    // Single report on ch1
    for (int i = 0; i < 3; i++) step("idle");
    set_ch(1, 'h12);
    step("single");
    for (int i = 0; i < 3; i++) step("single");

    // Simultaneous reports on all channels
    set_ch(0, 'h01); set_ch(1, 'h02); set_ch(2, 'h03);
    step("simul");
    for (int i = 0; i < 4; i++) step("simul");

    // Flush with four buffered entries and a push in the flush cycle
    set_ch(0, 'h21); set_ch(1, 'h22); set_ch(2, 'h23);
    step("flush");
    set_ch(0, 'h24); set_ch(2, 'h25);
    step("flush");
    bus.rtu_yy_xx_flush = 1'b1;
    set_ch(1, 'h26);
    step("flush");
    for (int i = 0; i < 3; i++) step("flush");

    // Fairness: ch0 streams, ch2 injects 0x55 once
    for (int i = 0; i < 10; i++) begin
      set_ch(0, 'h60 + i);
      if (i == 2) set_ch(2, 'h55);
      step("fair");
    end
    for (int i = 0; i < 4; i++) step("fair");

    // Back-pressure and overflow: all channels push every cycle
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        set_ch(k, next_id % 128);
        next_id++;
      end
      step("ovf");
    end
    for (int i = 0; i < 8; i++) step("ovf");

    // Asynchronous reset with three entries buffered and a completion on the port
    do_reset("rst2");
    set_ch(0, 'h41); set_ch(1, 'h42); set_ch(2, 'h43);
    step("midrst");
    set_ch(0, 'h44);
    step("midrst");
    #2;
    do_reset("midrst.async");
    set_ch(1, 'h33);
    step("midrst.after");
    for (int i = 0; i < 3; i++) step("midrst.after");

    // Randomized traffic at rising load, reset between rounds
    for (int r = 0; r < 4; r++) begin
      int unsigned pct;
      pct = (r == 0) ? 20 : (r == 1) ? 40 : (r == 2) ? 70 : 95;
      do_reset("rand.rst");
      for (int c = 0; c < 200; c++) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if ($urandom_range(99, 0) < pct) set_ch(k, $urandom_range(127, 0));
        end
        if ($urandom_range(99, 0) < 3) bus.rtu_yy_xx_flush = 1'b1;
        step("rand");
      end
      for (int c = 0; c < 8; c++) step("rand.drain");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
